// File: rtl/wb_dec_pkg.sv
// Shared types and 3DO address constants for the Wishbone bus decoder.
package wb_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STUB   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] MADAM_BASE   = 32'h0330_0000;
  localparam logic [31:0] CLIO_BASE    = 32'h0340_0000;
  localparam logic [31:0] SVF_ADDR0    = 32'h0320_6100;
  localparam logic [31:0] SVF_ADDR1    = 32'h0320_6900;
  localparam logic [31:0] SVF2_ADDR    = 32'h0320_02B4;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_region_match.sv
// Combinational masked address compare over N regions; lowest index wins the encode.
module wb_region_match #(
  parameter int unsigned N     = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [AW-1:0]    adr,
  input  logic [N*AW-1:0]  base,
  input  logic [N*AW-1:0]  mask,
  output logic [N-1:0]     hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    hit = '0;
    idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      hit[i] = ((adr & mask[i*AW +: AW]) == base[i*AW +: AW]);
    end
    // Scan downward so the lowest hitting index is the last one written.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (hit[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/wb_bus_decoder.sv
// Registered Wishbone address decoder with stub responses, default port and timeout.
// Optional WB_DEC_STATS_EN enables the saturating err_count timeout counter.
module wb_bus_decoder
  import wb_dec_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'h0360_0000, 32'h0350_0000, CLIO_BASE, MADAM_BASE},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {4{32'hFFFF_0000}},
  parameter int unsigned NUM_STUBS  = 3,
  parameter logic [((NUM_STUBS > 0) ? NUM_STUBS : 1)*ADDR_W-1:0] STUB_ADDR =
    {SVF2_ADDR, SVF_ADDR1, SVF_ADDR0},
  parameter logic [((NUM_STUBS > 0) ? NUM_STUBS : 1)*DATA_W-1:0] STUB_DATA =
    {32'h0000_0000, 32'hBADA_CCE5, 32'hBADA_CCE5},
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            m_adr,
  input  logic [DATA_W-1:0]            m_dat_w,
  input  logic [DATA_W/8-1:0]          m_sel,
  input  logic                         m_we,
  input  logic                         m_cyc,
  input  logic                         m_stb,
  output logic [DATA_W-1:0]            m_dat_r,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [ADDR_W-1:0]            s_adr,
  output logic [DATA_W-1:0]            s_dat_w,
  output logic [DATA_W/8-1:0]          s_sel,
  output logic                         s_we,
  output logic [NUM_SLAVES-1:0]        s_cyc,
  output logic [NUM_SLAVES-1:0]        s_stb,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_r,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  output logic                         d_cyc,
  output logic                         d_stb,
  input  logic [DATA_W-1:0]            d_dat_r,
  input  logic                         d_ack,
  output logic [15:0]                  err_count
);

  localparam int unsigned SEL_W  = DATA_W / 8;
  localparam int unsigned NS     = (NUM_STUBS > 0) ? NUM_STUBS : 1;
  localparam int unsigned SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned KIDX_W = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned CNT_W  = 16;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    tmo_q, tmo_n;
  logic [KIDX_W-1:0]   stub_idx_q, stub_idx_n;
  logic                stub_we_q, stub_we_n;

  logic [DATA_W-1:0]     m_dat_r_n;
  logic                  m_ack_n, m_err_n;
  logic [ADDR_W-1:0]     s_adr_n;
  logic [DATA_W-1:0]     s_dat_w_n;
  logic [SEL_W-1:0]      s_sel_n;
  logic                  s_we_n;
  logic [NUM_SLAVES-1:0] s_cyc_n, s_stb_n;
  logic                  d_cyc_n, d_stb_n;

  logic [NUM_SLAVES-1:0] slv_hit;
  logic [SIDX_W-1:0]     slv_idx;
  logic [NS-1:0]         stub_hit;
  logic [KIDX_W-1:0]     stub_idx;

  logic                  sel_ack;
  logic [DATA_W-1:0]     sel_dat;
  logic [DATA_W-1:0]     stub_dat;

  wb_region_match #(
    .N     (NUM_SLAVES),
    .AW    (ADDR_W),
    .IDX_W (SIDX_W)
  ) u_slv_match (
    .adr  (m_adr),
    .base (SLV_BASE),
    .mask (SLV_MASK),
    .hit  (slv_hit),
    .idx  (slv_idx)
  );

  generate
    if (NUM_STUBS > 0) begin : g_stub
      wb_region_match #(
        .N     (NUM_STUBS),
        .AW    (ADDR_W),
        .IDX_W (KIDX_W)
      ) u_stub_match (
        .adr  (m_adr),
        .base (STUB_ADDR),
        .mask ({(NUM_STUBS*ADDR_W){1'b1}}),
        .hit  (stub_hit),
        .idx  (stub_idx)
      );
    end else begin : g_nostub
      assign stub_hit = '0;
      assign stub_idx = '0;
    end
  endgenerate

  // Only the port whose strobe is live can complete the access.
  always_comb begin
    sel_ack = (d_cyc & d_ack) | (|(s_cyc & s_ack));
    sel_dat = d_dat_r;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (s_cyc[i]) sel_dat = s_dat_r[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    stub_dat = '0;
    for (int k = 0; k < int'(NS); k++) begin
      if (stub_idx_q == KIDX_W'(k)) stub_dat = STUB_DATA[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_n    = state_q;
    tmo_n      = tmo_q;
    stub_idx_n = stub_idx_q;
    stub_we_n  = stub_we_q;
    m_dat_r_n  = m_dat_r;
    m_ack_n    = 1'b0;
    m_err_n    = 1'b0;
    s_adr_n    = s_adr;
    s_dat_w_n  = s_dat_w;
    s_sel_n    = s_sel;
    s_we_n     = s_we;
    s_cyc_n    = s_cyc;
    s_stb_n    = s_stb;
    d_cyc_n    = d_cyc;
    d_stb_n    = d_stb;

    case (state_q)
      IDLE: begin
        if (m_cyc && m_stb) begin
          if (|stub_hit) begin
            state_n    = STUB;
            stub_idx_n = stub_idx;
            stub_we_n  = m_we;
          end else begin
            state_n   = ACTIVE;
            tmo_n     = '0;
            s_adr_n   = m_adr;
            s_dat_w_n = m_dat_w;
            s_sel_n   = m_sel;
            s_we_n    = m_we;
            if (|slv_hit) begin
              s_cyc_n = NUM_SLAVES'(1) << slv_idx;
              s_stb_n = NUM_SLAVES'(1) << slv_idx;
            end else begin
              d_cyc_n = 1'b1;
              d_stb_n = 1'b1;
            end
          end
        end
      end

      STUB: begin
        m_ack_n = 1'b1;
        if (!stub_we_q) m_dat_r_n = stub_dat;
        state_n = DONE;
      end

      ACTIVE: begin
        // Abort, then ack, then timeout: an ack in the timeout cycle still completes.
        if (!(m_cyc && m_stb)) begin
          s_cyc_n = '0;
          s_stb_n = '0;
          d_cyc_n = 1'b0;
          d_stb_n = 1'b0;
          state_n = IDLE;
        end else if (sel_ack) begin
          m_ack_n = 1'b1;
          if (!s_we) m_dat_r_n = sel_dat;
          s_cyc_n = '0;
          s_stb_n = '0;
          d_cyc_n = 1'b0;
          d_stb_n = 1'b0;
          state_n = DONE;
        end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
          m_err_n   = 1'b1;
          m_dat_r_n = ERR_DATA;
          s_cyc_n   = '0;
          s_stb_n   = '0;
          d_cyc_n   = 1'b0;
          d_stb_n   = 1'b0;
          state_n   = DONE;
        end else begin
          tmo_n = tmo_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      stub_idx_q <= '0;
      stub_we_q  <= 1'b0;
      m_dat_r    <= '0;
      m_ack      <= 1'b0;
      m_err      <= 1'b0;
      s_adr      <= '0;
      s_dat_w    <= '0;
      s_sel      <= '0;
      s_we       <= 1'b0;
      s_cyc      <= '0;
      s_stb      <= '0;
      d_cyc      <= 1'b0;
      d_stb      <= 1'b0;
    end else begin
      state_q    <= state_n;
      tmo_q      <= tmo_n;
      stub_idx_q <= stub_idx_n;
      stub_we_q  <= stub_we_n;
      m_dat_r    <= m_dat_r_n;
      m_ack      <= m_ack_n;
      m_err      <= m_err_n;
      s_adr      <= s_adr_n;
      s_dat_w    <= s_dat_w_n;
      s_sel      <= s_sel_n;
      s_we       <= s_we_n;
      s_cyc      <= s_cyc_n;
      s_stb      <= s_stb_n;
      d_cyc      <= d_cyc_n;
      d_stb      <= d_stb_n;
    end
  end

`ifdef WB_DEC_STATS_EN
  // m_err is only ever raised by a timeout, so its next value marks the event.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (m_err_n && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Self-checking bench for wb_bus_decoder: directed vector table, corner sequences, random traffic.
module tb_wb_bus_decoder;

  localparam int TMO = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  localparam logic [127:0] P_BASE = {32'h03000000, 32'h03500000, 32'h03400000, 32'h03300000};
  localparam logic [127:0] P_MASK = {32'hFF000000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000};
  localparam logic [95:0]  P_SADR = {32'h032002B4, 32'h03206900, 32'h03206100};
  localparam logic [95:0]  P_SDAT = {32'h00000000, 32'hBADACCE5, 32'hBADACCE5};

  logic [31:0] sl_base [4] = '{32'h03300000, 32'h03400000, 32'h03500000, 32'h03000000};
  logic [31:0] sl_mask [4] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFF000000};
  logic [31:0] st_adr  [3] = '{32'h03206100, 32'h03206900, 32'h032002B4};
  logic [31:0] st_dat  [3] = '{32'hBADACCE5, 32'hBADACCE5, 32'h00000000};

  logic         sys_clk, reset;
  logic [31:0]  m_adr, m_dat_w, m_dat_r, s_adr, s_dat_w, d_dat_r;
  logic [3:0]   m_sel, s_sel, s_cyc, s_stb;
  logic         m_we, m_cyc, m_stb, m_ack, m_err, s_we, d_cyc, d_stb;
  logic [127:0] s_dat_r;
  logic [3:0]   s_ack = '0;
  logic         d_ack = 1'b0;
  logic [15:0]  err_count;

  int checks = 0;
  int failures = 0;
  int ack_delay = -1;
  int cnt_s [4];
  int cnt_d = 0;
  logic [31:0] cur_dat = '0;
  int exp_errs = 0;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    int          dly;
    logic [31:0] rdat;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_dat;
    logic [3:0]  exp_stb;
    logic        exp_dstb;
  } vec_t;

  wb_bus_decoder #(
    .NUM_SLAVES (4),
    .ADDR_W     (32),
    .DATA_W     (32),
    .SLV_BASE   (P_BASE),
    .SLV_MASK   (P_MASK),
    .NUM_STUBS  (3),
    .STUB_ADDR  (P_SADR),
    .STUB_DATA  (P_SDAT),
    .TIMEOUT    (TMO),
    .ERR_DATA   (ERRD)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .m_adr     (m_adr),
    .m_dat_w   (m_dat_w),
    .m_sel     (m_sel),
    .m_we      (m_we),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_dat_r   (m_dat_r),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .s_adr     (s_adr),
    .s_dat_w   (s_dat_w),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_dat_r   (s_dat_r),
    .s_ack     (s_ack),
    .d_cyc     (d_cyc),
    .d_stb     (d_stb),
    .d_dat_r   (d_dat_r),
    .d_ack     (d_ack),
    .err_count (err_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Responder: ack in strobe cycle number ack_delay (0 = first), never when negative.
  always @(negedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (s_stb[i]) begin
        s_ack[i] = (cnt_s[i] == ack_delay);
        cnt_s[i] = cnt_s[i] + 1;
      end else begin
        s_ack[i] = 1'b0;
        cnt_s[i] = 0;
      end
    end
    if (d_stb) begin
      d_ack = (cnt_d == ack_delay);
      cnt_d = cnt_d + 1;
    end else begin
      d_ack = 1'b0;
      cnt_d = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_ec();
`ifdef WB_DEC_STATS_EN
    return 32'(exp_errs);
`else
    return 32'd0;
`endif
  endfunction

  // Target code: 10+k for stub k, i for slave i, 9 for the default port.
  function automatic int target_of(input logic [31:0] a);
    for (int k = 0; k < 3; k++) if (a == st_adr[k]) return 10 + k;
    for (int i = 0; i < 4; i++) if ((a & sl_mask[i]) == sl_base[i]) return i;
    return 9;
  endfunction

  function automatic vec_t model(input logic [31:0] a, input logic we, input int dly,
                                 input logic [31:0] rdat, input logic [31:0] prev);
    vec_t v;
    int t;
    t = target_of(a);
    v.adr = a; v.we = we; v.dly = dly; v.rdat = rdat;
    v.exp_stb = 4'b0; v.exp_dstb = 1'b0; v.exp_err = 1'b0;
    if (t >= 10) begin
      v.exp_lat = 2;
      v.exp_dat = we ? prev : st_dat[t-10];
    end else begin
      if (t == 9) v.exp_dstb = 1'b1;
      else        v.exp_stb  = 4'(1 << t);
      if (dly >= 0 && dly < TMO) begin
        v.exp_lat = dly + 2;
        v.exp_dat = we ? prev : rdat;
      end else begin
        v.exp_lat = TMO + 1;
        v.exp_err = 1'b1;
        v.exp_dat = ERRD;
      end
    end
    return v;
  endfunction

  task automatic apply(input vec_t v);
    int t;
    int lat;
    t = target_of(v.adr);
    for (int i = 0; i < 4; i++) s_dat_r[i*32 +: 32] = (t == i) ? v.rdat : (~v.rdat ^ 32'(i));
    d_dat_r = (t == 9) ? v.rdat : ~v.rdat;
    ack_delay = v.dly;
    @(negedge sys_clk);
    m_adr = v.adr; m_we = v.we; m_dat_w = $urandom; m_sel = 4'($urandom_range(1, 15));
    m_cyc = 1'b1; m_stb = 1'b1;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge sys_clk); #1;
      if (c == 1) begin
        chk("s_stb_decode", 32'(s_stb), 32'(v.exp_stb));
        chk("s_cyc_decode", 32'(s_cyc), 32'(v.exp_stb));
        chk("d_stb_decode", 32'(d_stb), 32'(v.exp_dstb));
        if (v.exp_stb != 4'b0 || v.exp_dstb) begin
          chk("s_adr_latch", s_adr, v.adr);
          chk("s_we_s_sel_latch", 32'({s_we, s_sel}), 32'({m_we, m_sel}));
          chk("s_dat_w_latch", s_dat_w, m_dat_w);
        end
      end
      if (m_ack || m_err) begin
        lat = c;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("ack_err_kind", 32'({m_ack, m_err}), v.exp_err ? 32'd1 : 32'd2);
    chk("m_dat_r", m_dat_r, v.exp_dat);
    chk("strobes_dropped", 32'({s_stb, s_cyc, d_stb, d_cyc}), 32'd0);
    if (v.exp_err) exp_errs++;
    cur_dat = v.exp_dat;
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge sys_clk); #1;
    chk("single_pulse", 32'({m_ack, m_err}), 32'd0);
    chk("err_count", 32'(err_count), exp_ec());
  endtask

  vec_t tbl [11];

  initial begin
    int acks;
    int bad;
    logic [31:0] a;
    vec_t v;

    reset = 1'b1; m_adr = '0; m_dat_w = '0; m_sel = '0; m_we = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; s_dat_r = '0; d_dat_r = '0;

    // adr, we, dly, rdat, lat, err, m_dat_r after, s_stb, d_stb
    tbl[0]  = '{32'h03400010, 1'b0,  0, 32'h12345678, 2, 1'b0, 32'h12345678, 4'b0010, 1'b0};
    tbl[1]  = '{32'h03206900, 1'b0,  0, 32'h11111111, 2, 1'b0, 32'hBADACCE5, 4'b0000, 1'b0};
    tbl[2]  = '{32'h032002B4, 1'b1,  0, 32'h22222222, 2, 1'b0, 32'hBADACCE5, 4'b0000, 1'b0};
    tbl[3]  = '{32'h00000100, 1'b0,  2, 32'hCAFEF00D, 4, 1'b0, 32'hCAFEF00D, 4'b0000, 1'b1};
    tbl[4]  = '{32'h03300000, 1'b1, -1, 32'h33333333, 9, 1'b1, 32'hDEADBEEF, 4'b0001, 1'b0};
    tbl[5]  = '{32'h03500010, 1'b0,  7, 32'hA5A50001, 9, 1'b0, 32'hA5A50001, 4'b0100, 1'b0};
    tbl[6]  = '{32'h03700000, 1'b0,  1, 32'h0BADF00D, 3, 1'b0, 32'h0BADF00D, 4'b1000, 1'b0};
    tbl[7]  = '{32'h03400000, 1'b0,  0, 32'h11112222, 2, 1'b0, 32'h11112222, 4'b0010, 1'b0};
    tbl[8]  = '{32'h032002B4, 1'b0,  0, 32'h44444444, 2, 1'b0, 32'h00000000, 4'b0000, 1'b0};
    tbl[9]  = '{32'h03500004, 1'b1,  3, 32'h55555555, 5, 1'b0, 32'h00000000, 4'b0100, 1'b0};
    tbl[10] = '{32'h03300000, 1'b0,  8, 32'h66666666, 9, 1'b1, 32'hDEADBEEF, 4'b0001, 1'b0};

    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_ctl", 32'({m_ack, m_err, s_cyc, s_stb, d_cyc, d_stb, s_we, s_sel}), 32'd0);
    chk("reset_dat", m_dat_r | s_adr | s_dat_w, 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    @(negedge sys_clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) apply(tbl[i]);

    // Strobe held across completions: one ack per 3-cycle decode pass.
    s_dat_r[31:0] = 32'h0F0F1234;
    ack_delay = 0;
    @(negedge sys_clk);
    m_adr = 32'h03300040; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    acks = 0; bad = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge sys_clk); #1;
      if (m_ack) acks++;
      if (m_err) bad++;
    end
    chk("held_stb_ack_count", 32'(acks), 32'd4);
    chk("held_stb_no_err", 32'(bad), 32'd0);
    chk("held_stb_data", m_dat_r, 32'h0F0F1234);
    cur_dat = 32'h0F0F1234;
    m_cyc = 1'b0; m_stb = 1'b0;
    repeat (2) @(posedge sys_clk);

    // Master abort while ACTIVE: strobes drop, no ack and no later timeout.
    ack_delay = -1;
    @(negedge sys_clk);
    m_adr = 32'h03500100; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge sys_clk); @(posedge sys_clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge sys_clk); #1;
    chk("abort_strobes", 32'({s_stb, s_cyc, d_stb}), 32'd0);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge sys_clk); #1;
      if (m_ack || m_err) bad++;
    end
    chk("abort_no_resp", 32'(bad), 32'd0);
    chk("abort_dat_hold", m_dat_r, cur_dat);

    // Reset asserted mid-transaction.
    @(negedge sys_clk);
    m_adr = 32'h03400080; m_we = 1'b1; m_cyc = 1'b1; m_stb = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge sys_clk); #1;
    chk("midrst_ctl", 32'({m_ack, m_err, s_cyc, s_stb, d_cyc, d_stb, s_we}), 32'd0);
    chk("midrst_dat", m_dat_r | s_adr | s_dat_w, 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    @(negedge sys_clk);
    reset = 1'b0;
    cur_dat = '0;
    exp_errs = 0;
    apply(model(32'h03400020, 1'b0, 1, 32'h76543210, cur_dat));

    // Random traffic against the address/latency model.
    for (int n = 0; n < 40; n++) begin
      int pick;
      int dly;
      pick = int'($urandom_range(0, 5));
      case (pick)
        0: a = st_adr[$urandom_range(0, 2)];
        1, 2, 3: a = sl_base[pick-1] | 32'($urandom_range(0, 16'hFFFF));
        4: a = 32'h03000000 | 32'($urandom_range(0, 24'hFFFFFF));
        default: begin
          a = $urandom;
          if (a[31:24] == 8'h03) a[31:24] = 8'h10;
        end
      endcase
      dly = int'($urandom_range(0, 10));
      if (dly == 10) dly = -1;
      v = model(a, 1'($urandom_range(0, 1)), dly, $urandom, cur_dat);
      apply(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_bus_decoder.md
Name: wb_bus_decoder

Overview:
- Parametrised Wishbone address decoder and read-data steering for the 3DO core.
- Sits between the ZAP master port and N slave ports (MADAM, CLIO, the matrix engine, and others). It also serves a small set of constant-response stub addresses and forwards unmapped addresses to a default port (BIOS/DRAM/VRAM via the sim).
- Adds what a flat combinational decode lacks: registered decode, per-slave handshake, a stub ack path, a bus-error timeout, and a clean single-cycle ack pulse.

Parameters:
- NUM_SLAVES, 4, number of decoded slave ports (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SLV_BASE, {32'h03300000,32'h03400000,32'h03500000,32'h03600000}, packed NUM_SLAVES*ADDR_W base addresses; index 0 in the LSBs.
- SLV_MASK, {4{32'hFFFF0000}}, packed match masks. A slave hits when (adr & mask) == base.
- NUM_STUBS, 3, number of constant-response addresses (0..8).
- STUB_ADDR, {32'h03206100,32'h03206900,32'h032002B4}, packed exact-match addresses.
- STUB_DATA, {32'hBADACCE5,32'hBADACCE5,32'h00000000}, packed read data, one entry per stub.
- TIMEOUT, 255, cycles to wait for a slave ack before raising an error (1..65535).
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- sys_clk in 1 — sole clock.
- reset in 1 — synchronous, active-high.
- m_adr in ADDR_W — master address.
- m_dat_w in DATA_W — master write data.
- m_sel in DATA_W/8 — byte selects.
- m_we in 1 — write enable.
- m_cyc in 1 — cycle.
- m_stb in 1 — strobe.
- m_dat_r out DATA_W — registered read data.
- m_ack out 1 — one-cycle ack pulse.
- m_err out 1 — one-cycle error pulse.
- s_adr out ADDR_W — shared slave address (latched).
- s_dat_w out DATA_W — shared slave write data (latched).
- s_sel out DATA_W/8 — shared slave byte selects (latched).
- s_we out 1 — shared slave write enable (latched).
- s_cyc out NUM_SLAVES — one-hot per-slave cycle.
- s_stb out NUM_SLAVES — one-hot per-slave strobe.
- s_dat_r in NUM_SLAVES*DATA_W — packed slave read data.
- s_ack in NUM_SLAVES — per-slave ack.
- d_cyc out 1 — default port cycle.
- d_stb out 1 — default port strobe.
- d_dat_r in DATA_W — default port read data.
- d_ack in 1 — default port ack.
- err_count out 16 — timeout counter (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Reset mid-operation: state returns to IDLE on the same edge and all strobes drop; no ack or err is issued.
- Decode priority, evaluated in IDLE only:
  - stub match, lowest index wins;
  - then slave match, lowest index wins;
  - otherwise the default port.
- Decode is registered. m_adr, m_dat_w, m_sel and m_we are latched into the s_* outputs on entry to ACTIVE.
- States:
  - IDLE: on m_cyc&m_stb:
    - stub hit -> STUB;
    - slave hit -> ACTIVE, s_cyc/s_stb[i]=1;
    - miss -> ACTIVE, d_cyc/d_stb=1.
  - STUB: m_ack=1 for one cycle. Reads return STUB_DATA[k]; writes are discarded. Next state DONE. Stub latency is 2 cycles from strobe to ack.
  - ACTIVE:
    - When the selected ack is 1: register the selected read data into m_dat_r, pulse m_ack, drop strobes, go to DONE. Minimum latency is 2 cycles (strobe edge -> slave ack at the next edge -> m_ack registered).
    - The timeout counter increments each cycle in ACTIVE. When it reaches TIMEOUT: m_err=1 for one cycle, m_dat_r=ERR_DATA, strobes drop, go to DONE.
    - If ack and timeout occur in the same cycle, ack wins.
    - If m_stb drops while ACTIVE (master abort): drop strobes, go to IDLE, no ack, no err.
  - DONE: one recovery cycle with no new decode, then IDLE. This prevents a held m_stb from retriggering.
- m_dat_r holds its value until the next completion. It is not updated for writes.
- m_ack and m_err are never both 1.
- Unused s_ack bits (non-selected slaves) are ignored.

Optional Feature:
- Macro: WB_DEC_STATS_EN.
- Defined: err_count increments by 1 on each timeout, saturates at 16'hFFFF, and clears only on reset.
- Undefined: err_count is tied to 0 and no counter logic is generated.

Decomposition:
- Package wb_dec_pkg holds:
  - the state enum (IDLE, STUB, ACTIVE, DONE);
  - 3DO default address constants (MADAM_BASE, CLIO_BASE, SVF_ADDR0/1, SVF2_ADDR);
  - the default ERR_DATA constant.
- One sub-module, wb_region_match: purely combinational. Takes the address plus packed base/mask vectors and returns a hit vector and the lowest-index encoded hit. It is instantiated once for slaves and once for stubs (the stub instance uses an all-ones mask).

Test Plan:
- Slave read: read 32'h03400010, s_ack[1] at the 1st strobe cycle with s_dat_r[1]=32'h12345678 -> s_stb=4'b0010, m_ack 2 cycles after m_stb, m_dat_r=32'h12345678, DONE then IDLE.
- Stub read: read 32'h03206900 -> no s_stb/d_stb asserted, m_ack at cycle 2, m_dat_r=32'hBADACCE5. A write to 32'h032002B4 -> m_ack, m_dat_r unchanged.
- Default/unmapped: read 32'h00000100 with d_ack after 3 cycles and d_dat_r=32'hCAFEF00D -> d_stb held 3 cycles, m_ack once, data matches.
- Timeout: TIMEOUT=8, write to 32'h03300000 with s_ack never asserted -> m_err pulse after 8 ACTIVE cycles, m_dat_r=32'hDEADBEEF, s_stb=0. With WB_DEC_STATS_EN defined, err_count=1.
- Boundaries:
  - ack on the same cycle the counter reaches TIMEOUT -> m_ack, no m_err;
  - m_stb held high across completion -> exactly one m_ack per DONE/IDLE pass;
  - overlapping masks -> lowest index selected.
- Reset mid-op: assert reset during ACTIVE -> next edge: all outputs 0, state IDLE, no ack; a subsequent read completes normally.
